// File: rtl/normalizer_if.sv
// Start/done handshake bundle for the normalizer.
//   master: drives start, In, Mode; observes busy, done, Out, Cnt, Zero
//   slave : the normalizer itself
interface normalizer_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  logic              start;
  logic [DATA_W-1:0] In;
  logic              Mode;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] Out;
  logic [CNT_W-1:0]  Cnt;
  logic              Zero;

  modport master (output start, In, Mode, input busy, done, Out, Cnt, Zero);
  modport slave  (input start, In, Mode, output busy, done, Out, Cnt, Zero);
endinterface

// File: rtl/normalizer.sv
// Iterative 16-bit left-normalizer: one 8/4/2/1 shift stage per clock,
// producing the normalizing left-shift count and the normalized value.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - normalizer_if.slave (start/In/Mode in; busy/done/Out/Cnt/Zero out)
module normalizer (
  input  logic        clk,
  input  logic        rst_n,
  normalizer_if.slave bus
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S8   = 3'd1,
    ST_S4   = 3'd2,
    ST_S2   = 3'd3,
    ST_S1   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] w_q, w_d;
  logic [CNT_W-1:0]  c_q, c_d;
  logic              mode_q;
  logic              zcap_q;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] out_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              zero_q;

  // Current stage evaluation: conditionally shift W and set the stage's count bit.
  always_comb begin
    w_d = w_q;
    c_d = c_q;
    case (state_q)
      ST_S8: begin
        if (mode_q ? (w_q[15:7] == {9{w_q[15]}}) : (w_q[15:8] == 8'h00)) begin
          w_d    = w_q << 8;
          c_d[3] = 1'b1;
        end
      end
      ST_S4: begin
        if (mode_q ? (w_q[15:11] == {5{w_q[15]}}) : (w_q[15:12] == 4'h0)) begin
          w_d    = w_q << 4;
          c_d[2] = 1'b1;
        end
      end
      ST_S2: begin
        if (mode_q ? (w_q[15:13] == {3{w_q[15]}}) : (w_q[15:14] == 2'b00)) begin
          w_d    = w_q << 2;
          c_d[1] = 1'b1;
        end
      end
      ST_S1: begin
        if (mode_q ? (w_q[15:14] == {2{w_q[15]}}) : (w_q[15] == 1'b0)) begin
          w_d    = w_q << 1;
          c_d[0] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequencer, working registers and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      c_q     <= '0;
      mode_q  <= 1'b0;
      zcap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      w_q <= w_d;
      c_q <= c_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= ST_S8;
            busy_q  <= 1'b1;
            w_q     <= bus.In;
            mode_q  <= bus.Mode;
            c_q     <= '0;
            zcap_q  <= (bus.In == '0);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_S8: state_q <= ST_S4;
        ST_S4: state_q <= ST_S2;
        ST_S2: state_q <= ST_S1;
        ST_S1: begin
          // Final stage result goes straight to the outputs.
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          out_q   <= w_d;
          cnt_q   <= c_d;
          zero_q  <= zcap_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Out  = out_q;
  assign bus.Cnt  = cnt_q;
  assign bus.Zero = zero_q;

endmodule

// File: tb/tb_normalizer.sv
// Self-checking bench for normalizer: directed table, handshake/reset
// sequences and random operands against a leading-bit-count model.
module tb_normalizer;

  logic clk;
  logic rst_n;
  normalizer_if nif ();

  normalizer u_dut (.clk(clk), .rst_n(rst_n), .bus(nif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [15:0] prev_out;
  logic [3:0]  prev_cnt;
  logic        prev_zero;

  typedef struct {
    logic [15:0] in;
    logic        mode;
    logic [15:0] out;
    logic [3:0]  cnt;
    logic        zero;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  // Count = number of leading bits equal to the reference bit, less one when
  // signed (sign bit itself is not redundant), capped at 15.
  function automatic void model(input logic [15:0] v, input logic m,
                                output logic [15:0] o, output logic [3:0] c,
                                output logic z);
    int n;
    logic ref_bit;
    n = 0;
    ref_bit = m ? v[15] : 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i] != ref_bit) break;
      n++;
    end
    if (m) n = n - 1;
    if (n > 15) n = 15;
    c = 4'(n);
    o = v << n;
    z = (v == 16'h0000);
  endfunction

  // One operation from IDLE/DONE: checks latency, hold of old result, new result.
  task automatic do_op(input logic [15:0] v, input logic m);
    logic [15:0] eo;
    logic [3:0]  ec;
    logic        ez;
    model(v, m, eo, ec, ez);
    @(negedge clk);
    nif.start = 1'b1;
    nif.In    = v;
    nif.Mode  = m;
    @(posedge clk); #1;
    chk("accept_busy", 32'(nif.busy), 32'd1);
    @(negedge clk);
    nif.start = 1'b0;
    nif.In    = ~v;
    nif.Mode  = ~m;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        chk("busy_mid", 32'(nif.busy), 32'd1);
        chk("done_early", 32'(nif.done), 32'd0);
        chk("hold_out", 32'(nif.Out), 32'(prev_out));
        chk("hold_cnt", 32'(nif.Cnt), 32'(prev_cnt));
      end else begin
        chk("done_e4", 32'(nif.done), 32'd1);
        chk("busy_e4", 32'(nif.busy), 32'd0);
      end
    end
    chk("out", 32'(nif.Out), 32'(eo));
    chk("cnt", 32'(nif.Cnt), 32'(ec));
    chk("zero", 32'(nif.Zero), 32'(ez));
    prev_out  = eo;
    prev_cnt  = ec;
    prev_zero = ez;
  endtask

  initial begin
    logic [15:0] eo, v;
    logic [3:0]  ec;
    logic        ez, m;
    int          ndone;
    logic [15:0] bb_in [6];
    logic        bb_md [6];

    vecs[0] = '{16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0};
    vecs[1] = '{16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0};
    vecs[2] = '{16'h00F0, 1'b0, 16'hF000, 4'd8,  1'b0};
    vecs[3] = '{16'h0001, 1'b1, 16'h4000, 4'd14, 1'b0};
    vecs[4] = '{16'hFFF0, 1'b1, 16'h8000, 4'd11, 1'b0};
    vecs[5] = '{16'h4000, 1'b1, 16'h4000, 4'd0,  1'b0};
    vecs[6] = '{16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b0};
    vecs[7] = '{16'h0000, 1'b0, 16'h0000, 4'd15, 1'b1};
    vecs[8] = '{16'h0000, 1'b1, 16'h0000, 4'd15, 1'b1};
    vecs[9] = '{16'h0100, 1'b0, 16'h8000, 4'd7,  1'b0};

    rst_n = 1'b0;
    nif.start = 1'b0;
    nif.In    = 16'h0;
    nif.Mode  = 1'b0;
    prev_out = 16'h0; prev_cnt = 4'd0; prev_zero = 1'b0;
    #12;
    chk("rst_busy", 32'(nif.busy), 32'd0);
    chk("rst_done", 32'(nif.done), 32'd0);
    chk("rst_out",  32'(nif.Out),  32'd0);
    chk("rst_cnt",  32'(nif.Cnt),  32'd0);
    chk("rst_zero", 32'(nif.Zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].in, vecs[i].mode);
      chk($sformatf("tbl%0d_out", i),  32'(nif.Out),  32'(vecs[i].out));
      chk($sformatf("tbl%0d_cnt", i),  32'(nif.Cnt),  32'(vecs[i].cnt));
      chk($sformatf("tbl%0d_zero", i), 32'(nif.Zero), 32'(vecs[i].zero));
    end

    // start re-pulsed while in S4 is ignored
    @(negedge clk);
    nif.start = 1'b1; nif.In = 16'h00F0; nif.Mode = 1'b0;
    @(posedge clk);                       // accept E
    @(negedge clk); nif.start = 1'b0;
    @(posedge clk);                       // E+1, now S4
    @(negedge clk); nif.start = 1'b1; nif.In = 16'h1234; nif.Mode = 1'b1;
    @(posedge clk);                       // E+2 sampled in S4
    @(negedge clk); nif.start = 1'b0;
    ndone = 0;
    for (int i = 3; i <= 10; i++) begin
      @(posedge clk); #1;
      if (nif.done) begin
        ndone++;
        chk("ign_done_edge", 32'(i), 32'd4);
      end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_out", 32'(nif.Out), 32'hF000);
    chk("ign_cnt", 32'(nif.Cnt), 32'd8);
    prev_out = 16'hF000; prev_cnt = 4'd8; prev_zero = 1'b0;

    // Back-to-back with start held high: done every 5 cycles
    bb_in = '{16'h0001, 16'hFFF0, 16'h0100, 16'h7FFF, 16'h0000, 16'h8001};
    bb_md = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    nif.start = 1'b1; nif.In = bb_in[0]; nif.Mode = bb_md[0];
    @(posedge clk); #1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      nif.In   = (j < 5) ? bb_in[j+1] : 16'hA5A5;
      nif.Mode = (j < 5) ? bb_md[j+1] : 1'b1;
      for (int i = 1; i <= 4; i++) begin
        @(posedge clk); #1;
        chk("bb_done", 32'(nif.done), (i == 4) ? 32'd1 : 32'd0);
      end
      model(bb_in[j], bb_md[j], eo, ec, ez);
      chk("bb_out", 32'(nif.Out), 32'(eo));
      chk("bb_cnt", 32'(nif.Cnt), 32'(ec));
      chk("bb_zero", 32'(nif.Zero), 32'(ez));
      if (j < 5) begin
        @(posedge clk); #1;
        chk("bb_accept_busy", 32'(nif.busy), 32'd1);
        chk("bb_accept_done", 32'(nif.done), 32'd0);
      end
    end
    @(negedge clk); nif.start = 1'b0;
    prev_out = eo; prev_cnt = ec; prev_zero = ez;
    @(posedge clk); #1;
    chk("bb_idle_done", 32'(nif.done), 32'd0);
    chk("bb_idle_busy", 32'(nif.busy), 32'd0);

    // Reset while in S2
    do_op(16'h00F0, 1'b0);
    @(negedge clk);
    nif.start = 1'b1; nif.In = 16'h0001; nif.Mode = 1'b0;
    @(posedge clk);
    @(negedge clk); nif.start = 1'b0;
    @(posedge clk); @(posedge clk); #2;   // state S2
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(nif.busy), 32'd0);
    chk("mrst_done", 32'(nif.done), 32'd0);
    chk("mrst_out",  32'(nif.Out),  32'd0);
    chk("mrst_cnt",  32'(nif.Cnt),  32'd0);
    chk("mrst_zero", 32'(nif.Zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    prev_out = 16'h0; prev_cnt = 4'd0; prev_zero = 1'b0;
    @(posedge clk); #1;
    chk("mrst_nodone", 32'(nif.done), 32'd0);
    do_op(16'h0003, 1'b0);
    chk("mrst_after_cnt", 32'(nif.Cnt), 32'd14);
    chk("mrst_after_out", 32'(nif.Out), 32'hC000);

    // Random operands, biased toward long leading runs
    for (int r = 0; r < 10000; r++) begin
      v = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) v = ~v;
      m = 1'($urandom_range(0, 1));
      do_op(v, m);
      chk("rnd_shift", 32'(nif.Out), 32'(16'(v << nif.Cnt)));
      if (!m) begin
        if (v != 16'h0000) chk("rnd_unorm", 32'(nif.Out[15]), 32'd1);
      end else begin
        if (v != 16'h0000 && v != 16'hFFFF)
          chk("rnd_snorm", 32'(nif.Out[15] ^ nif.Out[14]), 32'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
